data_ram_ctrl: RTL and testbench
================================

DATA_RAM_CTRL -- requirements
Module: data_ram_ctrl

Interface
REQ-001 SHALL have parameter MEMORY_DEPTH, default 64, number of DATA_WIDTH-bit words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width; multiple of 8.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h1001_0000, byte address of word 0.
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-007 SHALL have port Req_Valid_i  in  1  access request present.
REQ-008 SHALL have port Req_Ready_o  out  1  block accepts a request this cycle.
REQ-009 SHALL have port Write_Enable_i  in  1  1 = write, 0 = read.
REQ-010 SHALL have port Byte_Enable_i  in  DATA_WIDTH/8  per-byte write mask.
REQ-011 SHALL have port Address_i  in  ADDR_WIDTH  byte address.
REQ-012 SHALL have port Write_Data_i  in  DATA_WIDTH  write data.
REQ-013 SHALL have port Read_Data_o  out  DATA_WIDTH  registered read data.
REQ-014 SHALL have port Read_Valid_o  out  1  one-cycle pulse, Read_Data_o valid.
REQ-015 SHALL have port Addr_Error_o  out  1  one-cycle pulse, rejected access.
REQ-016 SHALL have port Init_Done_o  out  1  memory clear complete.

Function
REQ-017 SHALL implement FSM states INIT and READY; reset forces INIT.
REQ-018 In INIT, SHALL write zero to one word per cycle, index counter 0..MEMORY_DEPTH-1, then go to READY; INIT lasts exactly MEMORY_DEPTH cycles.
REQ-019 SHALL drive Req_Ready_o=0 and Init_Done_o=0 in INIT; Req_Ready_o=1 and Init_Done_o=1 in READY.
REQ-020 A request SHALL be accepted only on a cycle with Req_Valid_i=1 and Req_Ready_o=1; requests during INIT are ignored, not queued.
REQ-021 Word index SHALL be (Address_i - BASE_ADDR) >> log2(DATA_WIDTH/8), computed in ADDR_WIDTH bits without sign extension.
REQ-022 An access SHALL be rejected if Address_i < BASE_ADDR, index >= MEMORY_DEPTH, or low log2(DATA_WIDTH/8) address bits are nonzero.
REQ-023 Accepted write SHALL update only bytes whose Byte_Enable_i bit is 1 at the edge of acceptance; Byte_Enable_i=0 performs no update and no error.
REQ-024 Accepted read SHALL present word on Read_Data_o with Read_Valid_o=1 on the cycle after acceptance (latency 1).
REQ-025 Read issued on the cycle after a write to the same word SHALL return the newly written data.
REQ-026 Read_Data_o SHALL hold its last value until the next accepted valid read.
REQ-027 Rejected access SHALL not modify memory, SHALL pulse Addr_Error_o one cycle after acceptance, Read_Valid_o stays 0.
REQ-028 Back-to-back requests SHALL be accepted every cycle in READY; throughput 1 access/cycle.
REQ-029 Addr_Error_o and Read_Valid_o SHALL never be 1 in the same cycle.

Reset
REQ-030 With reset=0 at a rising edge: state=INIT, init counter=0, Read_Data_o=0, Read_Valid_o=0, Addr_Error_o=0, Init_Done_o=0, Req_Ready_o=0.
REQ-031 Reset asserted mid-INIT or mid-access SHALL restart a full clear; pending read responses SHALL be dropped.

Structure
REQ-032 Shared package data_ram_pkg SHALL hold the FSM state enum and BYTES_PER_WORD/byte-offset-width derivation functions.
REQ-033 Storage array SHALL be a sub-module byte_en_ram (single port, synchronous byte-masked write, registered read).

Verification
REQ-034 Reset then hold 64 cycles -> Init_Done_o rises on cycle 64; read 32'h1001_0000 returns 32'h0000_0000.
REQ-035 Write 32'hFFFF_FFFF to 32'h1001_0000, BE=4'hF, next cycle read same -> Read_Data_o=32'hFFFF_FFFF, Read_Valid_o=1 one cycle later.
REQ-036 Write 32'h1234_5678 to 32'h1001_0008, then 32'hABCD_EF12 with BE=4'b0011 -> read returns 32'h1234_EF12.
REQ-037 Access 32'h1001_0100 (index 64), 32'h1000_FFFC, 32'h1001_0002 -> Addr_Error_o pulse each, memory unchanged.
REQ-038 Writes to 32'h1001_000C=32'h9876_1234, 32'h1001_0010=32'hA0A0_A0A0 back-to-back, then back-to-back reads -> data returned in order, one per cycle.
REQ-039 Assert reset at cycle 30 of INIT and after writing 32'hA0A0_A0A0 -> full 64-cycle clear restarts, later read returns 0.

Source files
------------

// File: rtl/data_ram_pkg.sv
// data_ram_pkg
// Shared types and width helpers for the data RAM controller.
//   ram_state_t    : controller FSM state encoding
//   bytes_per_word : number of byte lanes in a data word
//   byte_off_width : number of low address bits that select a byte within a word
//   idx_width      : width of a word index (at least 1 bit)
package data_ram_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } ram_state_t;

  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned byte_off_width(input int unsigned data_width);
    return (data_width > 8) ? $clog2(data_width / 8) : 0;
  endfunction

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_ram_ctrl_if.sv
// data_ram_ctrl_if
// Request/response bus between a requester and the data RAM controller.
//   Req_Valid_i / Req_Ready_o : request handshake (accepted when both high)
//   Write_Enable_i            : 1 = write, 0 = read
//   Byte_Enable_i             : per-byte write mask
//   Address_i                 : byte address
//   Write_Data_i              : write data
//   Read_Data_o / Read_Valid_o: registered read data and its one-cycle strobe
//   Addr_Error_o              : one-cycle pulse for a rejected access
//   Init_Done_o               : memory clear complete
// The slave modport is used by the controller, master by the requester.
interface data_ram_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);

  logic                      Req_Valid_i;
  logic                      Req_Ready_o;
  logic                      Write_Enable_i;
  logic [DATA_WIDTH/8-1:0]   Byte_Enable_i;
  logic [ADDR_WIDTH-1:0]     Address_i;
  logic [DATA_WIDTH-1:0]     Write_Data_i;
  logic [DATA_WIDTH-1:0]     Read_Data_o;
  logic                      Read_Valid_o;
  logic                      Addr_Error_o;
  logic                      Init_Done_o;

  modport slave (
    input  Req_Valid_i, Write_Enable_i, Byte_Enable_i, Address_i, Write_Data_i,
    output Req_Ready_o, Read_Data_o, Read_Valid_o, Addr_Error_o, Init_Done_o
  );

  modport master (
    output Req_Valid_i, Write_Enable_i, Byte_Enable_i, Address_i, Write_Data_i,
    input  Req_Ready_o, Read_Data_o, Read_Valid_o, Addr_Error_o, Init_Done_o
  );

endinterface

// File: rtl/byte_en_ram.sv
// byte_en_ram
// Single-port word RAM with synchronous byte-masked write and registered read.
//   clk     : clock
//   reset   : synchronous active-low reset (clears the read register only)
//   i_we    : write strobe; only lanes with i_be set are updated
//   i_re    : read strobe; loads o_rdata from the addressed word
//   i_be    : byte lane mask
//   i_idx   : word index
//   i_wdata : write data
//   o_rdata : registered read data, holds until the next read strobe
module byte_en_ram
  import data_ram_pkg::*;
#(
  parameter  int unsigned DEPTH      = 64,
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned IDX_W      = idx_width(DEPTH),
  localparam int unsigned NBYTES     = bytes_per_word(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [NBYTES-1:0]     i_be,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Array contents are not reset; the controller clears them word by word.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < int'(NBYTES); b++) begin
        if (i_be[b]) r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl
// Memory-mapped data RAM controller. After reset it zeroes every word (one per
// cycle), then serves one read or write per cycle. Accesses below BASE_ADDR,
// beyond the last word, or not word-aligned are rejected with a one-cycle
// Addr_Error_o pulse and leave memory untouched.
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous active-low reset
//   bus   : request/response bus (slave side), see data_ram_ctrl_if
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_INIT  | clearing word r_init_cnt; requests ignored, not ready
// ST_READY | memory cleared; one request accepted per cycle
module data_ram_ctrl
  import data_ram_pkg::*;
#(
  parameter int unsigned           MEMORY_DEPTH = 64,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h1001_0000
) (
  input  logic           clk,
  input  logic           reset,
  data_ram_ctrl_if.slave bus
);

  localparam int unsigned NBYTES = bytes_per_word(DATA_WIDTH);
  localparam int unsigned OFF_W  = byte_off_width(DATA_WIDTH);
  localparam int unsigned IDX_W  = idx_width(MEMORY_DEPTH);

  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(MEMORY_DEPTH);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(MEMORY_DEPTH - 1);

  ram_state_t             r_state;
  ram_state_t             w_next_state;
  logic [IDX_W-1:0]       r_init_cnt;
  logic                   r_read_valid;
  logic                   r_addr_err;

  logic [ADDR_WIDTH-1:0]  w_offset;
  logic [ADDR_WIDTH-1:0]  w_word_idx;
  logic                   w_bad_addr;

  logic                   w_req_ready;
  logic                   w_init_done;
  logic                   w_ram_we;
  logic                   w_ram_re;
  logic [NBYTES-1:0]      w_ram_be;
  logic [IDX_W-1:0]       w_ram_idx;
  logic [DATA_WIDTH-1:0]  w_ram_wdata;
  logic                   w_err_set;
  logic [DATA_WIDTH-1:0]  w_ram_rdata;

  // Unsigned subtraction: addresses below the base wrap to a huge index,
  // but they are caught explicitly by the below-base compare anyway.
  assign w_offset   = bus.Address_i - BASE_ADDR;
  assign w_word_idx = w_offset >> OFF_W;
  assign w_bad_addr = (bus.Address_i < BASE_ADDR)
                    | (w_word_idx >= DEPTH_A)
                    | (|(bus.Address_i & OFF_MASK));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_INIT;
      r_init_cnt   <= '0;
      r_read_valid <= 1'b0;
      r_addr_err   <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + IDX_W'(1);
      r_read_valid <= w_ram_re;
      r_addr_err   <= w_err_set;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_req_ready  = 1'b0;
    w_init_done  = 1'b0;
    w_ram_we     = 1'b0;
    w_ram_re     = 1'b0;
    w_ram_be     = '0;
    w_ram_idx    = r_init_cnt;
    w_ram_wdata  = '0;
    w_err_set    = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_ram_we = 1'b1;
        w_ram_be = '1;
        if (r_init_cnt == LAST_IDX) w_next_state = ST_READY;
      end
      ST_READY: begin
        w_req_ready = 1'b1;
        w_init_done = 1'b1;
        w_ram_idx   = w_word_idx[IDX_W-1:0];
        w_ram_be    = bus.Byte_Enable_i;
        w_ram_wdata = bus.Write_Data_i;
        if (bus.Req_Valid_i) begin
          if (w_bad_addr)              w_err_set = 1'b1;
          else if (bus.Write_Enable_i) w_ram_we  = 1'b1;
          else                         w_ram_re  = 1'b1;
        end
      end
      default: w_next_state = ST_INIT;
    endcase
  end

  byte_en_ram #(
    .DEPTH      (MEMORY_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_be    (w_ram_be),
    .i_idx   (w_ram_idx),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign bus.Req_Ready_o  = w_req_ready;
  assign bus.Init_Done_o  = w_init_done;
  assign bus.Read_Data_o  = w_ram_rdata;
  assign bus.Read_Valid_o = r_read_valid;
  assign bus.Addr_Error_o = r_addr_err;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// tb_data_ram_ctrl
// Directed self-checking bench for data_ram_ctrl with default parameters.
module tb_data_ram_ctrl;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  data_ram_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_if ();

  data_ram_ctrl #(
    .MEMORY_DEPTH (64),
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (32),
    .BASE_ADDR    (BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic v, input logic we, input logic [3:0] be,
                     input logic [31:0] a, input logic [31:0] d);
    bus_if.Req_Valid_i    = v;
    bus_if.Write_Enable_i = we;
    bus_if.Byte_Enable_i  = be;
    bus_if.Address_i      = a;
    bus_if.Write_Data_i   = d;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    req(0, 0, 4'h0, 32'h0, 32'h0);
    tick();
    tick();
    chk("rst_ready",  {31'b0, bus_if.Req_Ready_o},  32'd0);
    chk("rst_done",   {31'b0, bus_if.Init_Done_o},  32'd0);
    chk("rst_rvalid", {31'b0, bus_if.Read_Valid_o}, 32'd0);
    chk("rst_err",    {31'b0, bus_if.Addr_Error_o}, 32'd0);
    chk("rst_rdata",  bus_if.Read_Data_o,           32'h0);

    // Clear phase: 64 cycles, a write attempted during the last two is ignored.
    reset = 1'b1;
    repeat (62) tick();
    chk("init_ready_mid", {31'b0, bus_if.Req_Ready_o}, 32'd0);
    req(1, 1, 4'hF, BASE + 32'h4, 32'hFFFF_FFFF);
    tick();
    chk("init_done_c63", {31'b0, bus_if.Init_Done_o}, 32'd0);
    tick();
    chk("init_done_c64", {31'b0, bus_if.Init_Done_o}, 32'd1);
    chk("ready_c64",     {31'b0, bus_if.Req_Ready_o}, 32'd1);
    chk("init_req_err",  {31'b0, bus_if.Addr_Error_o}, 32'd0);

    req(1, 0, 4'h0, BASE, 32'h0);
    tick();
    chk("rd0_valid", {31'b0, bus_if.Read_Valid_o}, 32'd1);
    chk("rd0_data",  bus_if.Read_Data_o,           32'h0);
    chk("rd0_err",   {31'b0, bus_if.Addr_Error_o}, 32'd0);
    req(1, 0, 4'h0, BASE + 32'h4, 32'h0);
    tick();
    chk("rd_init_ignored", bus_if.Read_Data_o, 32'h0);

    // Write then read-after-write on the next cycle.
    req(1, 1, 4'hF, BASE, 32'hFFFF_FFFF);
    tick();
    chk("wr_no_rvalid", {31'b0, bus_if.Read_Valid_o}, 32'd0);
    req(1, 0, 4'h0, BASE, 32'h0);
    tick();
    chk("raw_valid", {31'b0, bus_if.Read_Valid_o}, 32'd1);
    chk("raw_data",  bus_if.Read_Data_o,           32'hFFFF_FFFF);

    // Partial byte-enable merge.
    req(1, 1, 4'hF, BASE + 32'h8, 32'h1234_5678);
    tick();
    req(1, 1, 4'h3, BASE + 32'h8, 32'hABCD_EF12);
    tick();
    req(1, 0, 4'h0, BASE + 32'h8, 32'h0);
    tick();
    chk("be_merge", bus_if.Read_Data_o, 32'h1234_EF12);
    req(0, 0, 4'h0, 32'h0, 32'h0);
    tick();
    chk("hold_rvalid", {31'b0, bus_if.Read_Valid_o}, 32'd0);
    chk("hold_rdata",  bus_if.Read_Data_o,           32'h1234_EF12);

    // Rejected accesses.
    req(1, 1, 4'hF, BASE + 32'h100, 32'hDEAD_BEEF);
    tick();
    chk("err_range",        {31'b0, bus_if.Addr_Error_o}, 32'd1);
    chk("err_range_rvalid", {31'b0, bus_if.Read_Valid_o}, 32'd0);
    req(1, 0, 4'h0, 32'h1000_FFFC, 32'h0);
    tick();
    chk("err_below",        {31'b0, bus_if.Addr_Error_o}, 32'd1);
    chk("err_below_rvalid", {31'b0, bus_if.Read_Valid_o}, 32'd0);
    chk("err_below_hold",   bus_if.Read_Data_o,           32'h1234_EF12);
    req(1, 1, 4'hF, BASE + 32'h2, 32'hDEAD_BEEF);
    tick();
    chk("err_align", {31'b0, bus_if.Addr_Error_o}, 32'd1);
    req(0, 0, 4'h0, 32'h0, 32'h0);
    tick();
    chk("err_pulse_end", {31'b0, bus_if.Addr_Error_o}, 32'd0);
    req(1, 0, 4'h0, BASE, 32'h0);
    tick();
    chk("err_mem_unchanged", bus_if.Read_Data_o, 32'hFFFF_FFFF);

    // Last word is a legal address.
    req(1, 1, 4'hF, BASE + 32'hFC, 32'hCAFE_F00D);
    tick();
    chk("last_wr_err", {31'b0, bus_if.Addr_Error_o}, 32'd0);
    req(1, 0, 4'h0, BASE + 32'hFC, 32'h0);
    tick();
    chk("last_rd_data", bus_if.Read_Data_o,           32'hCAFE_F00D);
    chk("last_rd_err",  {31'b0, bus_if.Addr_Error_o}, 32'd0);

    // Zero byte enable: no update, no error.
    req(1, 1, 4'h0, BASE, 32'h0);
    tick();
    chk("be0_err", {31'b0, bus_if.Addr_Error_o}, 32'd0);
    req(1, 0, 4'h0, BASE, 32'h0);
    tick();
    chk("be0_data", bus_if.Read_Data_o, 32'hFFFF_FFFF);

    // Back-to-back writes and reads.
    req(1, 1, 4'hF, BASE + 32'hC, 32'h9876_1234);
    tick();
    req(1, 1, 4'hF, BASE + 32'h10, 32'hA0A0_A0A0);
    tick();
    req(1, 0, 4'h0, BASE + 32'hC, 32'h0);
    tick();
    chk("b2b_ready", {31'b0, bus_if.Req_Ready_o},  32'd1);
    chk("b2b_v0",    {31'b0, bus_if.Read_Valid_o}, 32'd1);
    chk("b2b_d0",    bus_if.Read_Data_o,           32'h9876_1234);
    req(1, 0, 4'h0, BASE + 32'h10, 32'h0);
    tick();
    chk("b2b_v1", {31'b0, bus_if.Read_Valid_o}, 32'd1);
    chk("b2b_d1", bus_if.Read_Data_o,           32'hA0A0_A0A0);

    // Reset during a read drops the response.
    req(1, 0, 4'h0, BASE + 32'h10, 32'h0);
    reset = 1'b0;
    tick();
    chk("rstrd_rvalid", {31'b0, bus_if.Read_Valid_o}, 32'd0);
    chk("rstrd_rdata",  bus_if.Read_Data_o,           32'h0);
    chk("rstrd_ready",  {31'b0, bus_if.Req_Ready_o},  32'd0);
    chk("rstrd_done",   {31'b0, bus_if.Init_Done_o},  32'd0);

    // Reset again at cycle 30 of the clear: a full clear must restart.
    req(0, 0, 4'h0, 32'h0, 32'h0);
    reset = 1'b1;
    repeat (30) tick();
    chk("mid_init_done", {31'b0, bus_if.Init_Done_o}, 32'd0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (63) tick();
    chk("reinit_c63", {31'b0, bus_if.Init_Done_o}, 32'd0);
    tick();
    chk("reinit_c64", {31'b0, bus_if.Init_Done_o}, 32'd1);
    req(1, 0, 4'h0, BASE + 32'h10, 32'h0);
    tick();
    chk("reinit_v10", {31'b0, bus_if.Read_Valid_o}, 32'd1);
    chk("reinit_d10", bus_if.Read_Data_o,           32'h0);
    req(1, 0, 4'h0, BASE + 32'hFC, 32'h0);
    tick();
    chk("reinit_dfc", bus_if.Read_Data_o, 32'h0);
    req(0, 0, 4'h0, 32'h0, 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
